// File: rtl/vga_pixel_fetch_if.sv
// Signal bundle between the VGA writer, the pixel fetch stage and the ZBT read arbiter.
// The master modport is the fetch stage. The slave modport is the writer/arbiter side.
interface vga_pixel_fetch_if #(
   parameter int unsigned ADDR_W = 19
) ();
   logic              vga_flag;
   logic [10:0]       clocked_hcount;
   logic [9:0]        clocked_vcount;
   logic [35:0]       vga_pixel;
   logic              done_vga;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic [35:0]       mem_rdata;

   modport master (
      input  vga_flag, clocked_hcount, clocked_vcount, mem_gnt, mem_rdata,
      output vga_pixel, done_vga, mem_req, mem_addr
   );

   modport slave (
      output vga_flag, clocked_hcount, clocked_vcount, mem_gnt, mem_rdata,
      input  vga_pixel, done_vga, mem_req, mem_addr
   );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Fetches one 36-bit word (two YCrCb pixels) per VGA writer request from ZBT memory.
// It also owns display double-buffer selection.
module vga_pixel_fetch #(
   parameter int unsigned       ADDR_W     = 19,
   parameter int unsigned       RD_LAT     = 2,
   parameter int unsigned       LINE_WORDS = 320,
   parameter logic [ADDR_W-1:0] BUF1_BASE  = ADDR_W'('h40000),
   parameter int unsigned       H_ACTIVE   = 640,
   parameter int unsigned       V_ACTIVE   = 480
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              frame_flag,
   vga_pixel_fetch_if.master bus,
   output logic              disp_buf,
   output logic              overrun
);

   localparam int unsigned      CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
   localparam logic [10:0]      H_LIM    = 11'(H_ACTIVE);
   localparam logic [9:0]       V_LIM    = 10'(V_ACTIVE);

   typedef enum logic [2:0] {StIdle, StCalc, StReq, StWait, StBlank} state_e;

   state_e            r_state, w_state_next;
   logic              r_flag_dly;
   logic [10:0]       r_h;
   logic [9:0]        r_v;
   logic [CNT_W-1:0]  r_cnt;
   logic [35:0]       r_pixel;
   logic              r_done;
   logic              r_mem_req;
   logic [ADDR_W-1:0] r_addr;
   logic              r_disp_buf;
   logic              r_pend_swap;
   logic              r_overrun;

   logic              w_edge, w_accept, w_blank, w_pend, w_swap;
   logic [ADDR_W-1:0] w_base, w_addr;

   always_comb begin
      w_edge   = bus.vga_flag & ~r_flag_dly;
      w_accept = w_edge & (r_state == StIdle);
      w_blank  = (r_h >= H_LIM) | (r_v >= V_LIM);
      w_pend   = r_pend_swap | frame_flag;
      // Swap only in a quiet idle cycle so a fetch never straddles two buffers
      w_swap   = (r_state == StIdle) & ~w_accept & w_pend;
      w_base   = r_disp_buf ? BUF1_BASE : '0;
      w_addr   = w_base + ADDR_W'(r_v) * ADDR_W'(LINE_WORDS) + ADDR_W'(r_h[10:1]);
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StCalc;
         StCalc:  w_state_next = w_blank ? StBlank : StReq;
         StReq:   if (bus.mem_gnt) w_state_next = StWait;
         StWait:  if (r_cnt == '0) w_state_next = StIdle;
         StBlank: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) r_state <= StIdle;
      else        r_state <= w_state_next;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_flag_dly  <= 1'b0;
         r_h         <= '0;
         r_v         <= '0;
         r_cnt       <= '0;
         r_pixel     <= '0;
         r_done      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_addr      <= '0;
         r_disp_buf  <= 1'b0;
         r_pend_swap <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_flag_dly <= bus.vga_flag;
         r_done     <= 1'b0;
         if (w_accept) begin
            r_h <= bus.clocked_hcount;
            r_v <= bus.clocked_vcount;
         end
         if (w_edge && (r_state != StIdle)) r_overrun <= 1'b1;
         if (w_swap) begin
            r_disp_buf  <= ~r_disp_buf;
            r_pend_swap <= 1'b0;
         end else begin
            r_pend_swap <= w_pend;
         end
         case (r_state)
            StCalc: begin
               r_addr    <= w_addr;
               r_mem_req <= ~w_blank;
            end
            StReq: begin
               if (bus.mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_cnt     <= CNT_LOAD;
               end
            end
            StWait: begin
               if (r_cnt == '0) begin
                  r_pixel <= bus.mem_rdata;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            StBlank: begin
               r_pixel <= '0;
               r_done  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.vga_pixel = r_pixel;
   assign bus.done_vga  = r_done;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_addr  = r_addr;
   assign disp_buf      = r_disp_buf;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: a transaction-timeline model is checked every cycle,
// and literal expectations pin the model.
module tb_vga_pixel_fetch;

   localparam int RD_LAT = 2;
   localparam logic [35:0] JUNK = 36'hDEADBEEF5;

   logic clock = 1'b0;
   logic reset;
   logic frame_flag;
   logic disp_buf;
   logic overrun;

   int n_vec = 0;
   int n_err = 0;

   vga_pixel_fetch_if #(.ADDR_W(19)) bus ();

   vga_pixel_fetch #(
      .ADDR_W    (19),
      .RD_LAT    (RD_LAT),
      .LINE_WORDS(320),
      .BUF1_BASE (19'h40000),
      .H_ACTIVE  (640),
      .V_ACTIVE  (480)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .frame_flag(frame_flag),
      .bus       (bus),
      .disp_buf  (disp_buf),
      .overrun   (overrun)
   );

   always #5 clock = ~clock;

   function automatic logic [35:0] mem_word(input logic [18:0] a);
      if (a == 19'd321) return 36'h123456789;
      return {a[17:0] ^ 18'h2AAAA, a[17:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Leaves the bench at the sample point just after the accepting edge
   task automatic pulse_flag(input int h, input int v);
      bus.clocked_hcount = 11'(h);
      bus.clocked_vcount = 10'(v);
      bus.vga_flag       = 1'b1;
      tick();
      bus.vga_flag       = 1'b0;
   endtask

   // Memory arbiter side: returns data RD_LAT cycles after an accepted read
   typedef struct {int due; logic [35:0] data;} rsp_t;
   rsp_t rq[$];

   initial begin : responder
      int k;
      k = 0;
      bus.mem_rdata = JUNK;
      forever begin
         @(posedge clock);
         k++;
         @(negedge clock);
         if (rq.size() > 0 && rq[0].due == k) begin
            bus.mem_rdata = rq[0].data;
            void'(rq.pop_front());
         end else begin
            bus.mem_rdata = JUNK;
         end
         if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1)
            rq.push_back('{k + RD_LAT, mem_word(bus.mem_addr)});
      end
   end

   // Timeline model: each accepted request is a transaction with a known completion edge
   initial begin : model
      int          mc, n0, done_at, a, h, v;
      bit          busy, blank, reqph, disp, pend, ovr, prev, done_exp, edge_s, was_busy, acc;
      bit          exp_req;
      logic [35:0] pix;
      logic [18:0] addr;
      mc = 0; n0 = 0; done_at = -1; busy = 0; blank = 0; reqph = 0; disp = 0; pend = 0;
      ovr = 0; prev = 0; pix = '0; addr = '0;
      forever begin
         @(posedge clock);
         mc++;
         done_exp = 0;
         if (!reset) begin
            busy = 0; reqph = 0; disp = 0; pend = 0; ovr = 0; prev = 0; pix = '0;
         end else begin
            edge_s   = bus.vga_flag && !prev;
            prev     = bus.vga_flag;
            was_busy = busy;
            acc      = edge_s && !was_busy;
            if (edge_s && was_busy) ovr = 1;
            if (was_busy && reqph && mc >= n0 + 2 && bus.mem_gnt) begin
               reqph   = 0;
               done_at = mc + RD_LAT;
            end
            if (was_busy && mc == done_at) begin
               done_exp = 1;
               pix      = blank ? 36'h0 : mem_word(addr);
               busy     = 0;
            end
            if (!was_busy && !acc && (pend || frame_flag)) begin
               disp = !disp;
               pend = 0;
            end else begin
               pend = pend || frame_flag;
            end
            if (acc) begin
               h       = int'(bus.clocked_hcount);
               v       = int'(bus.clocked_vcount);
               busy    = 1;
               n0      = mc;
               blank   = (h >= 640) || (v >= 480);
               a       = (disp ? 'h40000 : 0) + v * 320 + h / 2;
               addr    = a[18:0];
               reqph   = !blank;
               done_at = blank ? mc + 2 : -1;
            end
         end
         exp_req = busy && reqph && (mc >= n0 + 1);
         #1;
         chk("m_done", 64'(bus.done_vga), 64'(done_exp));
         chk("m_pixel", 64'(bus.vga_pixel), 64'(pix));
         chk("m_req", 64'(bus.mem_req), 64'(exp_req));
         if (exp_req) chk("m_addr", 64'(bus.mem_addr), 64'(addr));
         chk("m_disp", 64'(disp_buf), 64'(disp));
         chk("m_ovr", 64'(overrun), 64'(ovr));
      end
   end

   initial begin : stimulus
      int dcnt;
      reset = 1'b0; frame_flag = 1'b0;
      bus.vga_flag = 1'b0; bus.clocked_hcount = '0; bus.clocked_vcount = '0; bus.mem_gnt = 1'b1;

      // Reset for three cycles, then stay quiet
      repeat (3) tick();
      chk("rst_pixel", 64'(bus.vga_pixel), 64'h0);
      chk("rst_done", 64'(bus.done_vga), 64'h0);
      chk("rst_req", 64'(bus.mem_req), 64'h0);
      chk("rst_addr", 64'(bus.mem_addr), 64'h0);
      chk("rst_disp", 64'(disp_buf), 64'h0);
      chk("rst_ovr", 64'(overrun), 64'h0);
      reset = 1'b1;
      repeat (5) begin
         tick();
         chk("quiet_req", 64'(bus.mem_req), 64'h0);
         chk("quiet_done", 64'(bus.done_vga), 64'h0);
      end

      // Basic fetch, buffer 0, immediate grant
      pulse_flag(2, 1);
      tick();
      chk("t2_req", 64'(bus.mem_req), 64'h1);
      chk("t2_addr", 64'(bus.mem_addr), 64'd321);
      tick(); tick();
      chk("t2_done_early", 64'(bus.done_vga), 64'h0);
      tick();
      chk("t2_done", 64'(bus.done_vga), 64'h1);
      chk("t2_pixel", 64'(bus.vga_pixel), 64'h123456789);
      tick();
      chk("t2_done_pulse", 64'(bus.done_vga), 64'h0);
      chk("t2_pixel_hold", 64'(bus.vga_pixel), 64'h123456789);
      repeat (2) tick();

      // Swap to buffer 1 while idle, then fetch the last pair of the frame
      frame_flag = 1'b1;
      tick();
      frame_flag = 1'b0;
      chk("t3_disp", 64'(disp_buf), 64'h1);
      pulse_flag(639, 479);
      tick();
      chk("t3_addr", 64'(bus.mem_addr), 64'h657FF);
      repeat (3) tick();
      chk("t3_done", 64'(bus.done_vga), 64'h1);
      repeat (2) tick();

      // Out-of-range column: blank pixel, no memory access
      pulse_flag(700, 10);
      tick();
      chk("t4_req", 64'(bus.mem_req), 64'h0);
      chk("t4_done_early", 64'(bus.done_vga), 64'h0);
      tick();
      chk("t4_done", 64'(bus.done_vga), 64'h1);
      chk("t4_pixel", 64'(bus.vga_pixel), 64'h0);
      repeat (2) tick();

      // Grant withheld; a second request during it is dropped and flagged
      bus.mem_gnt = 1'b0;
      pulse_flag(20, 30);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("t5_req", 64'(bus.mem_req), 64'h1);
         chk("t5_addr", 64'(bus.mem_addr), 64'h4258A);
         if (i == 2) bus.vga_flag = 1'b1;
         if (i == 3) begin
            bus.vga_flag = 1'b0;
            chk("t5_ovr", 64'(overrun), 64'h1);
         end
      end
      bus.mem_gnt = 1'b1;
      dcnt = 0;
      repeat (12) begin
         tick();
         if (bus.done_vga === 1'b1) dcnt++;
      end
      chk("t5_one_done", 64'(dcnt), 64'd1);

      // Two frame_flag edges during a fetch: one swap, after done_vga
      pulse_flag(4, 2);
      tick();
      chk("t6_addr", 64'(bus.mem_addr), 64'h40282);
      tick();
      frame_flag = 1'b1;
      tick(); tick();
      chk("t6_done", 64'(bus.done_vga), 64'h1);
      chk("t6_disp_old", 64'(disp_buf), 64'h1);
      frame_flag = 1'b0;
      tick();
      chk("t6_disp_new", 64'(disp_buf), 64'h0);
      tick();
      chk("t6_no_double", 64'(disp_buf), 64'h0);

      // frame_flag coinciding with an accepted request: old buffer used, swap follows
      frame_flag = 1'b1;
      pulse_flag(0, 0);
      frame_flag = 1'b0;
      tick();
      chk("t6b_addr", 64'(bus.mem_addr), 64'h0);
      chk("t6b_disp", 64'(disp_buf), 64'h0);
      repeat (3) tick();
      chk("t6b_done", 64'(bus.done_vga), 64'h1);
      chk("t6b_disp_hold", 64'(disp_buf), 64'h0);
      tick();
      chk("t6b_disp_swap", 64'(disp_buf), 64'h1);
      repeat (2) tick();

      // Reset during WAIT abandons the fetch
      pulse_flag(6, 6);
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      chk("t6c_disp", 64'(disp_buf), 64'h0);
      chk("t6c_pixel", 64'(bus.vga_pixel), 64'h0);
      dcnt = 0;
      repeat (8) begin
         tick();
         if (bus.done_vga === 1'b1) dcnt++;
      end
      chk("t6c_no_done", 64'(dcnt), 64'd0);

      // Normal operation resumes after reset
      pulse_flag(10, 0);
      tick();
      chk("t7_addr", 64'(bus.mem_addr), 64'd5);
      repeat (3) tick();
      chk("t7_done", 64'(bus.done_vga), 64'h1);
      repeat (2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
